// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC NCO: arctangent table, start-vector gain and quadrant codes.
// The atan table is scaled so that 2^32 is one full turn; narrower phases take the upper bits.
package cordic_pkg;

    localparam logic [1:0] QUAD_0 = 2'b00;
    localparam logic [1:0] QUAD_1 = 2'b01;
    localparam logic [1:0] QUAD_2 = 2'b10;
    localparam logic [1:0] QUAD_3 = 2'b11;

    // 0.6072529 in Q1.31, the inverse of the accumulated CORDIC gain
    localparam logic [63:0] GAIN_Q31 = 64'd1304065672;

    localparam logic [31:0] ATAN_TAB [0:30] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001
    };

    function automatic int x_init(input int width);
        logic [63:0] amp;
        logic [63:0] prod;
        amp  = (64'd1 << (width - 1)) - 64'd1;
        prod = amp * GAIN_Q31;
        return int'(prod >> 31);
    endfunction

endpackage

// File: rtl/cordic_pipe.sv
// Fully pipelined rotation-mode CORDIC: quadrant fold, ITER micro-rotations, saturating output.
// Latency from inputs to outputs is ITER+2 clocks; outputs hold while no valid sample arrives.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PHASE_W = 32,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [PHASE_W-1:0] in_angle,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [TAG_W-1:0]   out_tag,
    output logic [WIDTH-1:0]   sin,
    output logic [WIDTH-1:0]   cos
);

    localparam int ITER = WIDTH - 1;
    localparam int XW   = WIDTH + 2;
    localparam logic signed [XW-1:0] X0      = XW'(x_init(WIDTH));
    localparam logic signed [XW-1:0] SAT_MAX = XW'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX;

    logic signed [XW-1:0]   r_x [0:ITER];
    logic signed [XW-1:0]   r_y [0:ITER];
    logic [PHASE_W-1:0]     r_z [0:ITER-1];
    logic                   r_v [0:ITER];
    logic [TAG_W-1:0]       r_t [0:ITER];

    function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX) begin
            sat = SAT_MAX[WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[WIDTH-1:0];
        end else begin
            sat = v[WIDTH-1:0];
        end
    endfunction

    // Fold into [-90,+90) by pre-rotating the start vector, then run the micro-rotations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ITER; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_v[i] <= 1'b0;
                r_t[i] <= '0;
            end
            for (int i = 0; i < ITER; i++) begin
                r_z[i] <= '0;
            end
        end else begin
            r_v[0] <= in_valid;
            r_t[0] <= in_tag;
            case (in_angle[PHASE_W-1 -: 2])
                QUAD_1: begin
                    r_x[0] <= '0;
                    r_y[0] <= X0;
                    r_z[0] <= {QUAD_0, in_angle[PHASE_W-3:0]};
                end
                QUAD_2: begin
                    r_x[0] <= '0;
                    r_y[0] <= -X0;
                    r_z[0] <= {QUAD_3, in_angle[PHASE_W-3:0]};
                end
                default: begin
                    r_x[0] <= X0;
                    r_y[0] <= '0;
                    r_z[0] <= in_angle;
                end
            endcase
            for (int i = 0; i < ITER; i++) begin
                r_v[i+1] <= r_v[i];
                r_t[i+1] <= r_t[i];
                if (r_z[i][PHASE_W-1]) begin
                    r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
                    r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
                end else begin
                    r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
                    r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
                end
            end
            for (int i = 0; i < ITER - 1; i++) begin
                if (r_z[i][PHASE_W-1]) begin
                    r_z[i+1] <= r_z[i] + ATAN_TAB[i][31 -: PHASE_W];
                end else begin
                    r_z[i+1] <= r_z[i] - ATAN_TAB[i][31 -: PHASE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            sin       <= '0;
            cos       <= '0;
        end else begin
            out_valid <= r_v[ITER];
            if (r_v[ITER]) begin
                out_tag <= r_t[ITER];
                cos     <= sat(r_x[ITER]);
                sin     <= sat(r_y[ITER]);
            end else begin
                out_tag <= out_tag;
            end
        end
    end

endmodule

// File: rtl/cordic_nco_mc.sv
// Multi-channel NCO: per-channel phase accumulators visited round-robin, one per clock,
// feeding a shared CORDIC pipeline that returns channel-tagged sin/cos.
module cordic_nco_mc
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int PHASE_W = 32,
    parameter int NCH     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    cfg_we,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [PHASE_W-1:0]      cfg_freq,
    input  logic                    cfg_clr,
    output logic                    out_valid,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic [WIDTH-1:0]        sin,
    output logic [WIDTH-1:0]        cos
);

    localparam int CH_W = $clog2(NCH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    logic [PHASE_W-1:0] r_freq [0:NCH-1];
    logic [PHASE_W-1:0] r_acc  [0:NCH-1];
    logic [CH_W-1:0]    r_ch_cnt;
    logic               r_iss_valid;
    logic [PHASE_W-1:0] r_iss_angle;
    logic [CH_W-1:0]    r_iss_tag;
    logic               w_issue;

    assign w_issue = en & ~cfg_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_freq[k] <= '0;
            end
        end else if (cfg_we && (cfg_ch <= LAST_CH)) begin
            r_freq[cfg_ch] <= cfg_freq;
        end else begin
            r_freq[0] <= r_freq[0];
        end
    end

    // The increment reads the pre-edge freq, so a same-edge write lands on the next visit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_acc[k] <= '0;
            end
            r_ch_cnt <= '0;
        end else if (cfg_clr) begin
            for (int k = 0; k < NCH; k++) begin
                r_acc[k] <= '0;
            end
            r_ch_cnt <= '0;
        end else if (en) begin
            r_acc[r_ch_cnt] <= r_acc[r_ch_cnt] + r_freq[r_ch_cnt];
            r_ch_cnt        <= (r_ch_cnt == LAST_CH) ? '0 : r_ch_cnt + 1'b1;
        end else begin
            r_ch_cnt <= r_ch_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss_angle <= '0;
            r_iss_tag   <= '0;
        end else begin
            r_iss_valid <= w_issue;
            if (w_issue) begin
                r_iss_angle <= r_acc[r_ch_cnt];
                r_iss_tag   <= r_ch_cnt;
            end else begin
                r_iss_tag   <= r_iss_tag;
            end
        end
    end

    cordic_pipe #(
        .WIDTH   (WIDTH),
        .PHASE_W (PHASE_W),
        .TAG_W   (CH_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_iss_valid),
        .in_angle  (r_iss_angle),
        .in_tag    (r_iss_tag),
        .out_valid (out_valid),
        .out_tag   (out_ch),
        .sin       (sin),
        .cos       (cos)
    );

endmodule

// File: tb/tb_cordic_nco_mc.sv
// Self-checking bench for cordic_nco_mc: directed and random stimulus against an
// integer CORDIC reference with per-channel phase bookkeeping and timed expectation queue.
module tb_cordic_nco_mc;

    localparam int    L      = 17;
    localparam int    NCH    = 32;
    localparam int    ITER   = 15;
    localparam int    X0     = 19897;
    localparam int    AMAX   = 32767;
    localparam real   TWO_PI = 6.283185307179586;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cfg_we;
    logic [4:0]  cfg_ch;
    logic [31:0] cfg_freq;
    logic        cfg_clr;
    logic        out_valid;
    logic [4:0]  out_ch;
    logic [15:0] sin;
    logic [15:0] cos;

    typedef struct {
        int ch;
        int c;
        int s;
        int due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic        mon_v;
    logic [31:0] m_freq [NCH];
    logic [31:0] m_acc  [NCH];
    logic [31:0] atan_ref [ITER];
    int          m_ch;
    int          cyc;
    int          errors;
    int          checks;
    int          last_c;
    int          last_s;
    int          last_ch;

    cordic_nco_mc #(.WIDTH(16), .PHASE_W(32), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_freq  (cfg_freq),
        .cfg_clr   (cfg_clr),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .sin       (sin),
        .cos       (cos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sat_ref(input longint v);
        if (v > AMAX) return AMAX;
        if (v < -AMAX) return -AMAX;
        return int'(v);
    endfunction

    // Rotate the gain-compensated unit vector by the given phase
    function automatic void cordic_ref(input logic [31:0] ang, output int c, output int s);
        longint      x;
        longint      y;
        longint      t;
        logic [31:0] z;
        logic [1:0]  quad;
        quad = ang[31:30];
        if (quad == 2'b01) begin
            x = 0; y = X0;  z = ang - 32'h4000_0000;
        end else if (quad == 2'b10) begin
            x = 0; y = -X0; z = ang + 32'h4000_0000;
        end else begin
            x = X0; y = 0;  z = ang;
        end
        for (int i = 0; i < ITER; i++) begin
            if (z[31]) begin
                t = x + (y >>> i); y = y - (x >>> i); z = z + atan_ref[i];
            end else begin
                t = x - (y >>> i); y = y + (x >>> i); z = z - atan_ref[i];
            end
            x = t;
        end
        c = sat_ref(x);
        s = sat_ref(y);
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < NCH; k++) begin
            m_freq[k] = 32'd0;
            m_acc[k]  = 32'd0;
        end
        m_ch    = 0;
        last_c  = 0;
        last_s  = 0;
        last_ch = 0;
    endtask

    task automatic tick(input logic e, input logic we, input logic [4:0] wch,
                        input logic [31:0] wf, input logic c);
        int cc;
        int ss;
        en = e; cfg_we = we; cfg_ch = wch; cfg_freq = wf; cfg_clr = c;
        @(posedge clk);
        cyc++;
        if (c) begin
            for (int k = 0; k < NCH; k++) m_acc[k] = 32'd0;
            m_ch = 0;
        end else if (e) begin
            cordic_ref(m_acc[m_ch], cc, ss);
            q.push_back('{m_ch, cc, ss, cyc + L});
            m_acc[m_ch] = m_acc[m_ch] + m_freq[m_ch];
            m_ch = (m_ch + 1) % NCH;
        end
        if (we) m_freq[wch] = wf;
        #1;
    endtask

    // Output monitor: every cycle either the due sample appears or the outputs hold
    always @(negedge clk) begin
        if (rst_n) begin
            mon_v = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", {63'd0, out_valid}, {63'd0, mon_v});
            if (mon_v) begin
                mon_e = q.pop_front();
                chk("out_ch", {59'd0, out_ch}, mon_e.ch);
                chk("cos", $signed(cos), mon_e.c);
                chk("sin", $signed(sin), mon_e.s);
                last_c  = mon_e.c;
                last_s  = mon_e.s;
                last_ch = mon_e.ch;
            end else begin
                chk("hold_cos", $signed(cos), last_c);
                chk("hold_sin", $signed(sin), last_s);
                chk("hold_ch", {59'd0, out_ch}, last_ch);
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        for (int i = 0; i < ITER; i++) begin
            atan_ref[i] = $rtoi($floor($atan(2.0 ** (-i)) / TWO_PI * 4294967296.0 + 0.5));
        end
        model_reset();
        rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_ch = 5'd0; cfg_freq = 32'd0; cfg_clr = 1'b0;
        #22;
        chk("rst_valid", {63'd0, out_valid}, 0);
        chk("rst_sin", $signed(sin), 0);
        chk("rst_cos", $signed(cos), 0);
        chk("rst_ch", {59'd0, out_ch}, 0);
        rst_n = 1'b1;

        // all frequencies zero: constant (x0-scaled) output, channels in order
        repeat (40) tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        // quarter-turn, half-turn and minus-one-LSB steps
        tick(1'b1, 1'b1, 5'd3, 32'h4000_0000, 1'b0);
        tick(1'b1, 1'b1, 5'd5, 32'h8000_0000, 1'b0);
        tick(1'b1, 1'b1, 5'd6, 32'hFFFF_FFFF, 1'b0);
        repeat (NCH * 6) tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        // ten-cycle issue gap mid-stream
        repeat (10) tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        repeat (40) tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        // write to the channel issued on the same edge
        tick(1'b1, 1'b1, 5'(m_ch), 32'h1000_0000, 1'b0);
        repeat (70) tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        // clear together with a config write, samples in flight drain
        tick(1'b1, 1'b1, 5'd7, 32'h2000_0000, 1'b1);
        repeat (50) tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        // random frequencies on every channel, then random traffic
        for (int k = 0; k < NCH; k++) tick(1'b1, 1'b1, 5'(k), $urandom, 1'b0);
        for (int n = 0; n < 10000; n++) begin
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
                 5'($urandom_range(0, NCH - 1)), $urandom, $urandom_range(0, 999) == 0);
        end

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 0);
        chk("arst_sin", $signed(sin), 0);
        chk("arst_cos", $signed(cos), 0);
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick(1'b1, 1'b1, 5'd0, 32'h0123_4567, 1'b0);
        tick(1'b1, 1'b1, 5'd1, 32'hC000_0000, 1'b0);
        repeat (70) tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

        repeat (L + 3) tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
